ex_muldiv_unit: RTL and testbench

//  Iterative multiply/divide unit in the EX stage, fed by the ID_EX pipeline latch.

---
 rtl/ex_muldiv_unit_pkg.sv | 25 ++
 rtl/ex_muldiv_unit_signfix.sv | 52 +++++
 rtl/ex_muldiv_unit.sv | 195 +++++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_unit_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: funct codes
// decoded by the unit and the FSM state encoding.
package ex_muldiv_unit_pkg;

   localparam logic [5:0] FN_MFHI  = 6'h10;
   localparam logic [5:0] FN_MTHI  = 6'h11;
   localparam logic [5:0] FN_MFLO  = 6'h12;
   localparam logic [5:0] FN_MTLO  = 6'h13;
   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_MULTU = 6'h19;
   localparam logic [5:0] FN_DIV   = 6'h1A;
   localparam logic [5:0] FN_DIVU  = 6'h1B;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_FIX  = 2'd3
   } state_t;

   function automatic logic is_signed_op(input logic [5:0] f);
      return (f == FN_MULT) || (f == FN_DIV);
   endfunction

endpackage

// File: rtl/ex_muldiv_unit_signfix.sv
// Sign handling around the unsigned iterative core: magnitude and result-sign
// extraction on entry, negation and divide-by-zero selection on exit.
module ex_muldiv_unit_signfix #(
   parameter int WIDTH = 32
) (
   input  logic             i_signed,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_abs_a,
   output logic [WIDTH-1:0] o_abs_b,
   output logic             o_neg_q,
   output logic             o_neg_r,

   input  logic             i_is_mul,
   input  logic             i_div0,
   input  logic             i_fix_neg_q,
   input  logic             i_fix_neg_r,
   input  logic [WIDTH-1:0] i_raw_a,
   input  logic [WIDTH-1:0] i_acc,
   input  logic [WIDTH-1:0] i_mq,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo
);

   logic [2*WIDTH-1:0] w_prod;
   logic [2*WIDTH-1:0] w_prod_fix;

   // |-2^(W-1)| = 2^(W-1) fits exactly in an unsigned WIDTH-bit magnitude.
   assign o_abs_a = (i_signed && i_a[WIDTH-1]) ? -i_a : i_a;
   assign o_abs_b = (i_signed && i_b[WIDTH-1]) ? -i_b : i_b;
   assign o_neg_q = i_signed && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
   assign o_neg_r = i_signed && i_a[WIDTH-1];

   assign w_prod     = {i_acc, i_mq};
   assign w_prod_fix = i_fix_neg_q ? -w_prod : w_prod;

   // NOTE: every output gets a default first, so no path leaves a latch behind.
   always_comb begin
      o_hi = '0;
      o_lo = '0;
      if (i_is_mul) begin
         {o_hi, o_lo} = w_prod_fix;
      end else if (i_div0) begin
         o_hi = i_raw_a;
         o_lo = '1;
      end else begin
         o_lo = i_fix_neg_q ? -i_mq  : i_mq;
         o_hi = i_fix_neg_r ? -i_acc : i_acc;
      end
   end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; one bit per cycle plus a
// final sign-fix cycle, with MTHI/MTLO serviced directly from IDLE.
module ex_muldiv_unit
   import ex_muldiv_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] bus_a,
   input  logic [WIDTH-1:0] bus_b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out
);

   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           r_state;
   state_t           w_next_state;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_opa;
   logic [WIDTH-1:0] r_opb;
   logic [WIDTH-1:0] r_mq;
   logic [WIDTH:0]   r_acc;
   logic [WIDTH-1:0] r_raw_a;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic             r_neg_q;
   logic             r_neg_r;
   logic             r_is_mul;
   logic             r_div0;
   logic             r_busy;
   logic             r_done;

   logic             w_idle_go;
   logic             w_mul_op;
   logic             w_div_op;
   logic             w_mthi;
   logic             w_mtlo;
   logic [WIDTH-1:0] w_abs_a;
   logic [WIDTH-1:0] w_abs_b;
   logic             w_neg_q;
   logic             w_neg_r;
   logic [WIDTH-1:0] w_fix_hi;
   logic [WIDTH-1:0] w_fix_lo;
   logic [WIDTH:0]   w_mul_sum;
   logic [WIDTH:0]   w_div_shift;
   logic [WIDTH:0]   w_div_diff;

   assign busy   = r_busy;
   assign done   = r_done;
   assign hi_out = r_hi;
   assign lo_out = r_lo;

   // A flush in IDLE suppresses both operation accept and MT* writes.
   assign w_idle_go = (r_state == ST_IDLE) && start && !flush;

   always_comb begin
      w_mul_op = 1'b0;
      w_div_op = 1'b0;
      w_mthi   = 1'b0;
      w_mtlo   = 1'b0;
      if (w_idle_go) begin
         case (funct)
            FN_MULT, FN_MULTU: w_mul_op = 1'b1;
            FN_DIV,  FN_DIVU:  w_div_op = 1'b1;
            FN_MTHI:           w_mthi   = 1'b1;
            FN_MTLO:           w_mtlo   = 1'b1;
            FN_MFHI, FN_MFLO:  ;
            default:           ;
         endcase
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_mul_op)      w_next_state = ST_MUL;
            else if (w_div_op) w_next_state = ST_DIV;
         end
         ST_MUL, ST_DIV: begin
            if (flush)              w_next_state = ST_IDLE;
            else if (r_cnt == LAST) w_next_state = ST_FIX;
         end
         ST_FIX:  w_next_state = ST_IDLE;
         default: w_next_state = ST_IDLE;
      endcase
   end

   // Multiply keeps {acc, mq} as the partial product shifting right; divide
   // keeps acc as partial remainder and mq as dividend-in / quotient-out.
   assign w_mul_sum   = r_mq[0] ? (r_acc + {1'b0, r_opa}) : r_acc;
   assign w_div_shift = {r_acc[WIDTH-1:0], r_mq[WIDTH-1]};
   assign w_div_diff  = w_div_shift - {1'b0, r_opb};

   ex_muldiv_unit_signfix #(
      .WIDTH (WIDTH)
   ) u_signfix (
      .i_signed    (is_signed_op(funct)),
      .i_a         (bus_a),
      .i_b         (bus_b),
      .o_abs_a     (w_abs_a),
      .o_abs_b     (w_abs_b),
      .o_neg_q     (w_neg_q),
      .o_neg_r     (w_neg_r),
      .i_is_mul    (r_is_mul),
      .i_div0      (r_div0),
      .i_fix_neg_q (r_neg_q),
      .i_fix_neg_r (r_neg_r),
      .i_raw_a     (r_raw_a),
      .i_acc       (r_acc[WIDTH-1:0]),
      .i_mq        (r_mq),
      .o_hi        (w_fix_hi),
      .o_lo        (w_fix_lo)
   );

   // NOTE: non-blocking assignments throughout, so every register samples
   // the pre-edge values of the others regardless of statement order.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_opa    <= '0;
         r_opb    <= '0;
         r_mq     <= '0;
         r_acc    <= '0;
         r_raw_a  <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_is_mul <= 1'b0;
         r_div0   <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_busy  <= (w_next_state != ST_IDLE);
         r_done  <= (r_state == ST_FIX) && !flush;

         if (w_mul_op || w_div_op) begin
            r_opa    <= w_abs_a;
            r_opb    <= w_abs_b;
            r_mq     <= w_mul_op ? w_abs_b : w_abs_a;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_neg_q  <= w_neg_q;
            r_neg_r  <= w_neg_r;
            r_is_mul <= w_mul_op;
            r_div0   <= (bus_b == '0);
            r_raw_a  <= bus_a;
         end

         if (w_mthi) r_hi <= bus_a;
         if (w_mtlo) r_lo <= bus_a;

         case (r_state)
            ST_MUL: begin
               if (!flush) begin
                  r_acc <= {1'b0, w_mul_sum[WIDTH:1]};
                  r_mq  <= {w_mul_sum[0], r_mq[WIDTH-1:1]};
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            ST_DIV: begin
               if (!flush) begin
                  if (!w_div_diff[WIDTH]) begin
                     r_acc <= w_div_diff;
                     r_mq  <= {r_mq[WIDTH-2:0], 1'b1};
                  end else begin
                     r_acc <= w_div_shift;
                     r_mq  <= {r_mq[WIDTH-2:0], 1'b0};
                  end
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            ST_FIX: begin
               if (!flush) begin
                  r_hi <= w_fix_hi;
                  r_lo <= w_fix_lo;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed-vector bench for ex_muldiv_unit: arithmetic results, latency,
// done pulse, MT* handling, flush and mid-operation reset.
module tb_ex_muldiv_unit;

   localparam logic [5:0] F_MTHI  = 6'h11;
   localparam logic [5:0] F_MTLO  = 6'h13;
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_DIV   = 6'h1A;
   localparam logic [5:0] F_DIVU  = 6'h1B;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [5:0]  funct;
   logic [31:0] bus_a;
   logic [31:0] bus_b;
   logic        flush;
   logic        busy;
   logic        done;
   logic [31:0] hi_out;
   logic [31:0] lo_out;

   int n_cmp = 0;
   int n_bad = 0;

   ex_muldiv_unit #(.WIDTH(32)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .funct  (funct),
      .bus_a  (bus_a),
      .bus_b  (bus_b),
      .flush  (flush),
      .busy   (busy),
      .done   (done),
      .hi_out (hi_out),
      .lo_out (lo_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Issue one mul/div, then follow it to completion (33 busy cycles, done pulse).
   task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int ncyc;
      @(negedge clk);
      start = 1'b1; funct = f; bus_a = a; bus_b = b;
      @(negedge clk);
      start = 1'b0;
      check({tag, "_done_early"}, 64'(done), 64'd0);
      ncyc = 0;
      while (busy && ncyc < 100) begin
         ncyc++;
         @(negedge clk);
      end
      check({tag, "_busy_cycles"}, 64'(ncyc), 64'd33);
      check({tag, "_done"}, 64'(done), 64'd1);
      check({tag, "_hi"}, 64'(hi_out), 64'(exp_hi));
      check({tag, "_lo"}, 64'(lo_out), 64'(exp_lo));
      @(negedge clk);
      check({tag, "_done_once"}, 64'(done), 64'd0);
   endtask

   task automatic do_mt(input logic [5:0] f, input logic [31:0] a);
      @(negedge clk);
      start = 1'b1; funct = f; bus_a = a;
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      int ncyc;
      reset = 1'b0; start = 1'b0; flush = 1'b0;
      funct = 6'h00; bus_a = '0; bus_b = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_hi", 64'(hi_out), 64'd0);
      check("rst_lo", 64'(lo_out), 64'd0);
      reset = 1'b1;

      run_op("mult_m3x5",   F_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1);
      run_op("multu_max",   F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
      run_op("mult_min_sq", F_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
      run_op("div_m7_2",    F_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
      run_op("div_7_m2",    F_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
      run_op("divu_100_7",  F_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E);
      run_op("divu_by0",    F_DIVU,  32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF);
      run_op("div_m5_by0",  F_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF);
      run_op("div_ovf",     F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

      // MTHI/MTLO from IDLE: one edge, never busy.
      do_mt(F_MTHI, 32'h00001234);
      check("mthi_hi", 64'(hi_out), 64'h1234);
      check("mthi_busy", 64'(busy), 64'd0);
      do_mt(F_MTLO, 32'h00005678);
      check("mtlo_lo", 64'(lo_out), 64'h5678);

      // MTLO and a second MULT while busy must be ignored.
      @(negedge clk);
      start = 1'b1; funct = F_MULTU; bus_a = 32'd3; bus_b = 32'd4;
      @(negedge clk);
      ncyc = 0;
      while (busy && ncyc < 100) begin
         ncyc++;
         start = 1'b0;
         if (ncyc == 5) begin
            start = 1'b1; funct = F_MTLO; bus_a = 32'hDEADBEEF;
         end
         if (ncyc == 8) begin
            start = 1'b1; funct = F_MULT; bus_a = 32'd9; bus_b = 32'd9;
         end
         if (ncyc == 7) check("mtlo_busy_lo", 64'(lo_out), 64'h5678);
         @(negedge clk);
      end
      start = 1'b0;
      check("busy_ign_cycles", 64'(ncyc), 64'd33);
      check("busy_ign_hi", 64'(hi_out), 64'd0);
      check("busy_ign_lo", 64'(lo_out), 64'd12);
      @(negedge clk);
      check("busy_ign_idle", 64'(busy), 64'd0);

      // Flush mid-multiply leaves HI/LO alone and never pulses done.
      do_mt(F_MTHI, 32'h0000AAAA);
      do_mt(F_MTLO, 32'h00005555);
      @(negedge clk);
      start = 1'b1; funct = F_MULT; bus_a = 32'd7; bus_b = 32'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      check("flush_pre_busy", 64'(busy), 64'd1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_busy", 64'(busy), 64'd0);
      check("flush_done", 64'(done), 64'd0);
      check("flush_hi", 64'(hi_out), 64'hAAAA);
      check("flush_lo", 64'(lo_out), 64'h5555);
      repeat (30) @(negedge clk);
      check("flush_no_done", 64'(done), 64'd0);
      check("flush_keep_lo", 64'(lo_out), 64'h5555);

      // Flush in IDLE blocks both an accept and an MT* write.
      @(negedge clk);
      start = 1'b1; flush = 1'b1; funct = F_MULT; bus_a = 32'd3; bus_b = 32'd3;
      @(negedge clk);
      funct = F_MTHI; bus_a = 32'h0000BEEF;
      check("flush_idle_busy", 64'(busy), 64'd0);
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      check("flush_idle_hi", 64'(hi_out), 64'hAAAA);

      // Reset mid-operation clears everything; reset beats a concurrent flush.
      @(negedge clk);
      start = 1'b1; funct = F_DIVU; bus_a = 32'd50; bus_b = 32'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      reset = 1'b0; flush = 1'b1;
      @(negedge clk);
      reset = 1'b1; flush = 1'b0;
      check("rstmid_busy", 64'(busy), 64'd0);
      check("rstmid_done", 64'(done), 64'd0);
      check("rstmid_hi", 64'(hi_out), 64'd0);
      check("rstmid_lo", 64'(lo_out), 64'd0);

      run_op("post_rst_divu", F_DIVU, 32'd50, 32'd3, 32'h00000002, 32'h00000010);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
